// File: rtl/detection_scheduler.sv
// detection_scheduler: periodic frame sequencer with stage timeouts and a hysteretic majority vote
module detection_scheduler #(
    parameter int PERIOD_W       = 24,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int WINDOW         = 5,
    parameter int ON_THRESH      = 3,
    parameter int OFF_THRESH     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period_cycles,
    output logic                capture_trigger,
    input  logic                valid_to_read,
    input  logic                detection_valid,
    input  logic                crossing_detected,
    input  logic [7:0]          stripe_count,
    output logic                crossing_confirmed,
    output logic                confirm_valid,
    output logic [7:0]          last_stripe_count,
    output logic [15:0]         frame_count,
    output logic                timeout_err,
    output logic                busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, TRIGGER, WAIT_CAPTURE, WAIT_DETECT, VOTE, WAIT_PERIOD} state_t;

    state_t              state, nxt;
    logic [PERIOD_W-1:0] pcnt;
    logic [TW-1:0]       tcnt;
    logic [WINDOW-1:0]   hist, hist_nxt;
    logic                res;
    logic [7:0]          stripe;
    logic                waiting, accept, tmo, pdone;
    int                  hits;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // next-state: a detection wins over a capture-ready, which wins over a timeout
    always_comb begin
        nxt = state;
        case (state)
            IDLE:         nxt = enable ? TRIGGER : IDLE;
            TRIGGER:      nxt = WAIT_CAPTURE;
            WAIT_CAPTURE: nxt = accept ? VOTE : valid_to_read ? WAIT_DETECT : tmo ? WAIT_PERIOD : WAIT_CAPTURE;
            WAIT_DETECT:  nxt = accept ? VOTE : tmo ? WAIT_PERIOD : WAIT_DETECT;
            VOTE:         nxt = WAIT_PERIOD;
            WAIT_PERIOD:  nxt = !enable ? IDLE : pdone ? TRIGGER : WAIT_PERIOD;
            default:      nxt = IDLE;
        endcase
    end

    // state-decoded outputs and strobes; pcnt counts the trigger cycle itself, so <=1 means the period has elapsed
    always_comb begin
        waiting         = (state == WAIT_CAPTURE) || (state == WAIT_DETECT);
        accept          = waiting && detection_valid;
        tmo             = waiting && !accept && !(state == WAIT_CAPTURE && valid_to_read) && (tcnt == TMAX);
        pdone           = pcnt <= PERIOD_W'(1);
        capture_trigger = state == TRIGGER;
        busy            = state != IDLE;
    end

    // history shifted by one result and its popcount
    always_comb begin
        hist_nxt = WINDOW'({hist, res});
        hits = 0;
        for (int i = 0; i < WINDOW; i++) hits += int'(hist_nxt[i]);
    end

    // period and stage-timeout counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            tcnt <= '0;
        end else begin
            pcnt <= (state == TRIGGER) ? ((period_cycles == '0) ? '0 : period_cycles - PERIOD_W'(1))
                  : (pcnt == '0) ? pcnt : pcnt - PERIOD_W'(1);
            tcnt <= (state == TRIGGER || (state == WAIT_CAPTURE && nxt == WAIT_DETECT)) ? '0
                  : waiting ? tcnt + TW'(1) : tcnt;
        end
    end

    // result latch, vote history and frame-level outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res                <= 1'b0;
            stripe             <= '0;
            hist               <= '0;
            crossing_confirmed <= 1'b0;
            confirm_valid      <= 1'b0;
            last_stripe_count  <= '0;
            frame_count        <= '0;
            timeout_err        <= 1'b0;
        end else begin
            res                <= accept ? crossing_detected : res;
            stripe             <= accept ? stripe_count : stripe;
            hist               <= (state == VOTE) ? hist_nxt : hist;
            crossing_confirmed <= (state != VOTE) ? crossing_confirmed
                                : (hits >= ON_THRESH) ? 1'b1
                                : (hits <= OFF_THRESH) ? 1'b0 : crossing_confirmed;
            confirm_valid      <= state == VOTE;
            last_stripe_count  <= (state == VOTE) ? stripe : last_stripe_count;
            frame_count        <= (state == VOTE) ? frame_count + 16'd1 : frame_count;
            timeout_err        <= tmo;
        end
    end
endmodule

// File: tb/tb_detection_scheduler.sv
// tb_detection_scheduler: scoreboard bench with a frame-level reference model
module tb_detection_scheduler;
    localparam int TMO = 64;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [23:0] period_cycles = '0;
    logic        valid_to_read = 1'b0, detection_valid = 1'b0, crossing_detected = 1'b0;
    logic [7:0]  stripe_count = '0;
    logic        capture_trigger, crossing_confirmed, confirm_valid, timeout_err, busy;
    logic [7:0]  last_stripe_count;
    logic [15:0] frame_count;

    detection_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period_cycles(period_cycles),
        .capture_trigger(capture_trigger), .valid_to_read(valid_to_read),
        .detection_valid(detection_valid), .crossing_detected(crossing_detected),
        .stripe_count(stripe_count), .crossing_confirmed(crossing_confirmed),
        .confirm_valid(confirm_valid), .last_stripe_count(last_stripe_count),
        .frame_count(frame_count), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          tmo;
        bit          conf;
        logic [7:0]  stripe;
        logic [15:0] frames;
        int          at;
    } exp_t;

    exp_t        sb[$];
    bit          hq[$];
    bit          m_conf = 0;
    logic [7:0]  m_stripe = '0;
    logic [15:0] m_frames = '0;
    int          exp_next = -1;

    function automatic void model_vote(bit r, logic [7:0] s, int at);
        int h;
        hq.push_back(r);
        if (hq.size() > 5) void'(hq.pop_front());
        h = 0;
        foreach (hq[i]) h += int'(hq[i]);
        m_conf = (h >= 3) ? 1'b1 : (h <= 1) ? 1'b0 : m_conf;
        m_stripe = s;
        m_frames = m_frames + 16'd1;
        sb.push_back('{1'b0, m_conf, m_stripe, m_frames, at});
    endfunction

    function automatic void model_tmo(int at);
        sb.push_back('{1'b1, m_conf, m_stripe, m_frames, at});
    endfunction

    function automatic void model_reset();
        hq.delete();
        m_conf = 0;
        m_stripe = '0;
        m_frames = '0;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (confirm_valid || timeout_err)) begin
            if (sb.size() == 0) chk("unexpected_event", 1, 0);
            else begin
                e = sb.pop_front();
                chk("event_timeout", timeout_err, e.tmo);
                chk("event_confirm", confirm_valid, !e.tmo);
                chk("event_cycle", cyc, e.at);
                chk("crossing_confirmed", crossing_confirmed, e.conf);
                chk("last_stripe_count", last_stripe_count, e.stripe);
                chk("frame_count", frame_count, e.frames);
            end
        end
    end

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_trig(output int t);
        int n = 0;
        while (!capture_trigger && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!capture_trigger) chk("trigger_wait_expired", 0, 1);
        t = cyc;
        if (exp_next >= 0) chk("trigger_cycle", t, exp_next);
    endtask

    // kind 0: normal frame, 1: capture never ready, 2: detector never answers
    task automatic run_frame(input int p, input int kind, input int c, input int d, input bit r, input logic [7:0] s);
        int t, e;
        period_cycles = 24'(p);
        wait_trig(t);
        if (kind == 1) begin
            e = t + TMO + 1;
            model_tmo(e);
        end else begin
            wait_to(t + c);
            valid_to_read = 1'b1;
            if (kind == 2) begin
                e = t + c + 1 + TMO;
                model_tmo(e);
            end else begin
                wait_to(t + c + d);
                detection_valid = 1'b1;
                crossing_detected = r;
                stripe_count = s;
                e = t + c + d + 2;
                model_vote(r, s, e);
                @(negedge clk);
                detection_valid = 1'b0;
            end
        end
        wait_to(e);
        valid_to_read = 1'b0;
        exp_next = enable ? ((t + p > e + 1) ? t + p : e + 1) : -1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit hyst[7] = '{1, 1, 0, 1, 0, 0, 0};
        bit conf_exp[7] = '{0, 0, 0, 1, 1, 1, 0};
        int t, trig_seen;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {capture_trigger, crossing_confirmed, confirm_valid, last_stripe_count, frame_count, timeout_err, busy}, 0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_outputs", {capture_trigger, crossing_confirmed, confirm_valid, last_stripe_count, frame_count, timeout_err, busy}, 0);
        end

        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_frame(100, 0, 20, 10, hyst[i], 8'(i + 1));
            chk("hysteresis_pattern", crossing_confirmed, conf_exp[i]);
        end

        run_frame(40, 1, 0, 0, 0, 0);
        run_frame(100, 2, 5, 0, 0, 0);
        run_frame(10, 0, 30, 10, 1, 8'h21);
        run_frame(10, 0, 30, 10, 1, 8'h22);

        period_cycles = 24'd100;
        wait_trig(t);
        wait_to(t + 20);
        valid_to_read = 1'b1;
        wait_to(t + 23);
        enable = 1'b0;
        wait_to(t + 30);
        detection_valid = 1'b1;
        crossing_detected = 1'b0;
        stripe_count = 8'd7;
        model_vote(0, 8'd7, t + 32);
        @(negedge clk);
        detection_valid = 1'b0;
        valid_to_read = 1'b0;
        wait_to(t + 32);
        chk("busy_after_drop_vote", busy, 1);
        @(negedge clk);
        chk("busy_idle_after_drop", busy, 0);
        trig_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            trig_seen += int'(capture_trigger);
        end
        chk("no_trigger_when_disabled", trig_seen, 0);
        chk("confirm_held_in_idle", crossing_confirmed, m_conf);
        chk("last_stripe_after_drop", last_stripe_count, 7);

        exp_next = -1;
        enable = 1'b1;
        wait_trig(t);
        wait_to(t + 5);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", {capture_trigger, crossing_confirmed, confirm_valid, last_stripe_count, frame_count, timeout_err, busy}, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("no_trigger_in_reset", {capture_trigger, busy}, 0);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            int sel = $urandom_range(0, 9);
            run_frame($urandom_range(0, 60), (sel == 0) ? 1 : (sel == 1) ? 2 : 0,
                      $urandom_range(1, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                detection_valid = 1'b1;
                crossing_detected = 1'b1;
                @(negedge clk);
                detection_valid = 1'b0;
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/detection_scheduler.md
Name: detection_scheduler

Overview:
- Frame-level controller for the edge-detect → BRAM capture → zebra-crossing detector chain.
- Issues periodic capture triggers and tracks each frame through capture and detection, with per-stage timeouts.
- Filters per-frame detection results through a sliding-window majority vote with hysteresis, producing a debounced crossing flag for downstream control logic.

Parameters:
- PERIOD_W, 24, width of period_cycles and the period counter.
- TIMEOUT_CYCLES, 1000000, max cycles allowed in WAIT_CAPTURE or in WAIT_DETECT.
- WINDOW, 5, number of frame results in vote history (1..16).
- ON_THRESH, 3, hits in window at or above which confirmation asserts.
- OFF_THRESH, 1, hits in window at or below which confirmation deasserts; must be < ON_THRESH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  level; run periodic detection while high.
- period_cycles  in  PERIOD_W  trigger spacing in cycles; sampled at each TRIGGER.
- capture_trigger  out  1  one-cycle pulse to the image BRAM.
- valid_to_read  in  1  level from BRAM; high when a captured frame is readable.
- detection_valid  in  1  one-cycle pulse from detector.
- crossing_detected  in  1  per-frame result; qualified by detection_valid.
- stripe_count  in  8  per-frame stripe count; qualified by detection_valid.
- crossing_confirmed  out  1  debounced crossing flag.
- confirm_valid  out  1  one-cycle pulse; vote updated.
- last_stripe_count  out  8  stripe_count latched on the last accepted detection.
- frame_count  out  16  accepted frames; wraps 0xFFFF→0.
- timeout_err  out  1  one-cycle pulse on a stage timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, vote history cleared, state IDLE, all counters 0.
- States: IDLE, TRIGGER, WAIT_CAPTURE, WAIT_DETECT, VOTE, WAIT_PERIOD.
- IDLE → TRIGGER when enable=1.
- TRIGGER (1 cycle):
  - Assert capture_trigger.
  - Load period counter with period_cycles; counter decrements each cycle, saturating at 0.
  - Clear stage timeout counter.
  - → WAIT_CAPTURE.
- WAIT_CAPTURE:
  - valid_to_read=1 → WAIT_DETECT.
  - If detection_valid=1 in the same cycle, accept it and go directly to VOTE.
  - Timeout counter reaching TIMEOUT_CYCLES-1 → pulse timeout_err next cycle, → WAIT_PERIOD.
- WAIT_DETECT:
  - detection_valid=1 → latch crossing_detected and stripe_count, → VOTE.
  - Timeout counter is cleared on entry; timeout handled as in WAIT_CAPTURE.
- VOTE (1 cycle):
  - Shift the latched result into the WINDOW-bit history; oldest bit drops out.
  - Compute hits as the popcount of the updated history.
  - If hits ≥ ON_THRESH, set crossing_confirmed; else if hits ≤ OFF_THRESH, clear it; otherwise hold.
  - Pulse confirm_valid.
  - Update last_stripe_count.
  - frame_count += 1.
  - All of these outputs become visible the cycle after VOTE.
  - → WAIT_PERIOD.
- WAIT_PERIOD:
  - Period counter = 0 and enable=1 → TRIGGER.
  - enable=0 → IDLE.
  - If processing exceeded the period, the counter is already 0, so re-trigger happens immediately with no extra idle cycles.
  - period_cycles=0 or 1 also means back-to-back frames.
- enable deassert mid-frame: the current frame completes (vote or timeout), then WAIT_PERIOD → IDLE. No new trigger is issued.
- Timed-out frames do not enter the history and do not increment frame_count.
- crossing_confirmed holds its value across IDLE. Only rst clears it and the history.
- detection_valid pulses outside WAIT_CAPTURE/WAIT_DETECT are ignored.
- Async rst mid-frame: immediate return to IDLE, outputs 0. No capture_trigger is issued until rst deasserts and enable is sampled high.

Test Plan:
- Reset/idle: enable=0 for 50 cycles → capture_trigger never pulses, busy=0, all outputs 0.
- Period spacing: period_cycles=100; model responds with valid_to_read 20 cycles after trigger and detection_valid 10 cycles later → capture_trigger pulses every 100 cycles; confirm_valid once per frame.
- Hysteresis (WINDOW=5, ON=3, OFF=1):
  - Results 1,1,0,1 → crossing_confirmed rises after the 4th vote.
  - Further results 0,0,0 → confirmed clears after the 3rd zero (history 1,0,0,0 → hits=1).
- Timeout (TIMEOUT_CYCLES=64): valid_to_read never asserts → timeout_err pulses 64 cycles after WAIT_CAPTURE entry; frame_count unchanged; next trigger follows the period rule.
- Overrun: period_cycles=10, detection takes 40 cycles → next trigger is 2 cycles after detection_valid (VOTE, WAIT_PERIOD), with no idle gap beyond that.
- Enable drop and reset: deassert enable in WAIT_DETECT → frame completes, stripe_count=7 appears on last_stripe_count, then IDLE. Assert rst mid-WAIT_CAPTURE → all outputs 0 in the same cycle.
